hash_checker: RTL and testbench
===============================

HASH_CHECKER -- requirements
Module: hash_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port `clk`, input, 1 bit: system clock.
REQ-003 Port `reset_n`, input, 1 bit: synchronous active-low reset.
REQ-004 Port `start`, input, 1 bit: begin a check; sampled only in IDLE.
REQ-005 Port `msg_len`, input, 4 bits: message byte count (0..8), sampled with `start`.
REQ-006 Port `expected_hash`, input, 32 bits: reference hash, sampled with `start`.
REQ-007 Port `in_valid`, input, 1 bit: `in_byte` holds a valid byte.
REQ-008 Port `in_byte`, input, 8 bits: message byte, first byte first.
REQ-009 Port `in_ready`, output, 1 bit: block accepts a byte this cycle.
REQ-010 Port `busy`, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port `done`, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 Port `match`, output, 1 bit: computed hash equals `expected_hash`.
REQ-013 Port `error`, output, 1 bit: `msg_len` was greater than 8.
REQ-014 Port `hash_out`, output, 32 bits: computed hash.

Function
REQ-015 The FSM SHALL have four states: IDLE, ABSORB, FINAL and DONE.
REQ-016 In IDLE with `start`=1, the block SHALL capture `msg_len` and `expected_hash`, set H=32'hFFFF_FFFF and count=0, and clear `match` and `error`.
REQ-017 On that `start`, the next state SHALL be DONE with `error`=1 if `msg_len`>8, FINAL if `msg_len`=0, and ABSORB otherwise.
REQ-018 `in_ready` SHALL be 1 only in ABSORB; a byte SHALL be accepted on a cycle with `in_valid`=1 and `in_ready`=1.
REQ-019 For each accepted byte b: H <= rotl(H,5) XOR {24'h0,b}, and count increments.
REQ-020 When the accepted byte brings count to `msg_len`, the next state SHALL be FINAL.
REQ-021 ABSORB SHALL wait indefinitely while `in_valid`=0; no timeout applies.
REQ-022 FINAL SHALL take exactly one cycle: H <= rotl(H, msg_len), a left rotate by 0..8 positions (rotate by 0 is identity).
REQ-023 DONE SHALL take one cycle: `done`=1, `hash_out`=H, `match`=(H==expected_hash), then the next state is IDLE.
REQ-024 `hash_out`, `match` and `error` SHALL be registered and SHALL hold their values until the next accepted `start` or reset.
REQ-025 With `error`=1, `match` SHALL be 0, `hash_out` SHALL be 32'hFFFF_FFFF, and no bytes SHALL be accepted.
REQ-026 A `start` outside IDLE SHALL be ignored, and a `start` in the DONE cycle SHALL also be ignored.
REQ-027 Latency from `start` to `done` SHALL be 2 cycles for length 0, N+2 cycles for N back-to-back bytes, and 1 cycle on error.
REQ-028 `in_valid` outside ABSORB SHALL have no effect, and `in_byte` SHALL be ignored when `in_valid`=0.
REQ-029 All arithmetic SHALL be 32-bit rotate/XOR with no carries; count SHALL be 4 bits.

Reset
REQ-030 On `reset_n`=0 at a clock edge: state=IDLE; H=32'hFFFF_FFFF; count=0; `in_ready`, `busy`, `done`, `match` and `error` SHALL be 0; `hash_out`=32'h0.
REQ-031 A reset asserted mid-operation, in any state, SHALL abort the check without a `done` pulse; the first `start` after reset SHALL behave normally.

Verification
REQ-032 `start`, `msg_len`=0, `expected_hash`=32'hFFFF_FFFF -> `done` 2 cycles later, `hash_out`=32'hFFFF_FFFF, `match`=1.
REQ-033 `msg_len`=1, byte 8'hFF, `expected_hash`=32'hFFFF_FE01 -> `hash_out`=32'hFFFF_FE01, `match`=1.
REQ-034 `msg_len`=2, bytes 8'h01 then 8'h02, `expected_hash`=32'h0 -> `hash_out`=32'hFFFF_FF77, `match`=0; repeat with `in_valid` gaps -> same result, `done` delayed by the gap count.
REQ-035 `msg_len`=9 -> `done` 1 cycle later with `error`=1, `match`=0, `in_ready` never asserted.
REQ-036 `msg_len`=8, 8 bytes 8'h00 -> `hash_out`=32'hFFFF_FFFF; a second `start` during ABSORB is ignored.
REQ-037 Reset asserted after 3 of 8 bytes -> all outputs return to reset values; a following zero-length check passes as in REQ-032.

Source files
------------

// File: rtl/hash_checker.sv
// rtl/hash_checker.sv - rotate/XOR message hash with compare against a reference value
module hash_checker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  msg_len,
  input  logic [31:0] expected_hash,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        error,
  output logic [31:0] hash_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] H_INIT  = 32'hFFFF_FFFF;
  localparam logic [3:0]  MAX_LEN = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  len_q;
  logic [31:0] exp_q;
  logic [31:0] h_q;
  logic [3:0]  count_q;
  logic [31:0] hash_q;
  logic        match_q;
  logic        error_q;
  logic [31:0] h_final;

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [3:0] k);
    logic [63:0] w;
    w = {v, v} << k;
    return w[63:32];
  endfunction

  assign h_final = rotl(h_q, len_q);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (msg_len > MAX_LEN)    state_d = DONE;
          else if (msg_len == 4'd0) state_d = FINAL;
          else                      state_d = ABSORB;
        end
      end
      ABSORB: begin
        in_ready = 1'b1;
        if (in_valid && (count_q + 4'd1 == len_q)) state_d = FINAL;
      end
      FINAL: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers are loaded on the FINAL edge so they are already valid during the done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q   <= 4'd0;
      exp_q   <= 32'h0;
      h_q     <= H_INIT;
      count_q <= 4'd0;
      hash_q  <= 32'h0;
      match_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= msg_len;
            exp_q   <= expected_hash;
            h_q     <= H_INIT;
            count_q <= 4'd0;
            match_q <= 1'b0;
            error_q <= (msg_len > MAX_LEN);
            if (msg_len > MAX_LEN) hash_q <= H_INIT;
          end
        end
        ABSORB: begin
          if (in_valid) begin
            h_q     <= rotl(h_q, 4'd5) ^ {24'h0, in_byte};
            count_q <= count_q + 4'd1;
          end
        end
        FINAL: begin
          h_q     <= h_final;
          hash_q  <= h_final;
          match_q <= (h_final == exp_q);
        end
        default: ;
      endcase
    end
  end

  assign hash_out = hash_q;
  assign match    = match_q;
  assign error    = error_q;

endmodule

// File: tb/tb_hash_checker.sv
// tb/tb_hash_checker.sv - randomized self-checking bench for hash_checker
module tb_hash_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  msg_len;
  logic [31:0] expected_hash;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        match;
  logic        error;
  logic [31:0] hash_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] msg_bytes [0:7];

  always #5 clk = ~clk;

  hash_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_len(msg_len),
    .expected_hash(expected_hash), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .busy(busy), .done(done), .match(match),
    .error(error), .hash_out(hash_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: rotate-left by k as a plain 32-bit circular shift.
  function automatic logic [31:0] ref_rotl(input logic [31:0] v, input int k);
    if (k == 0) return v;
    return (v << k) | (v >> (32 - k));
  endfunction

  function automatic logic [31:0] ref_hash(input int n);
    logic [31:0] h;
    h = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) h = ref_rotl(h, 5) ^ {24'h0, msg_bytes[i]};
    return ref_rotl(h, n);
  endfunction

  // One full check; gap_pct controls how often in_valid is withheld in ABSORB.
  task automatic run_check(input string tag, input int len, input logic [31:0] exp_h,
                           input int gap_pct, input bit poke_start);
    int cycles, gaps, idx, exp_lat;
    bit seen_done, ready_seen;
    logic [31:0] want_hash;
    bit want_match, want_err;
    want_err   = (len > 8);
    want_hash  = want_err ? 32'hFFFF_FFFF : ref_hash(len);
    want_match = !want_err && (want_hash == exp_h);
    @(negedge clk);
    start = 1'b1; msg_len = 4'(len); expected_hash = exp_h;
    in_valid = 1'($urandom_range(0, 1)); in_byte = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    cycles = 1; gaps = 0; idx = 0; seen_done = 0; ready_seen = 0;
    while (cycles < 200) begin
      if (done) begin seen_done = 1; break; end
      if (in_ready) ready_seen = 1;
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      msg_len = 4'($urandom); expected_hash = $urandom;
      in_byte = 8'($urandom);
      if (in_ready) begin
        if (idx < len && $urandom_range(0, 99) >= gap_pct) begin
          in_valid = 1'b1; in_byte = msg_bytes[idx]; idx++;
        end else begin
          in_valid = 1'b0; gaps++;
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; in_valid = 1'b0;
    exp_lat = want_err ? 1 : (len + 2 + gaps);
    check({tag, " done_seen"}, 32'(seen_done), 32'd1);
    check({tag, " latency"}, cycles, exp_lat);
    check({tag, " hash_out"}, hash_out, want_hash);
    check({tag, " match"}, 32'(match), 32'(want_match));
    check({tag, " error"}, 32'(error), 32'(want_err));
    if (want_err) check({tag, " no_in_ready"}, 32'(ready_seen), 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " hold"}, {error, match, hash_out[29:0]},
          {want_err, want_match, want_hash[29:0]});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " match"}, 32'(match), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " hash_out"}, hash_out, 32'h0);
  endtask

  initial begin
    int len;
    reset_n = 1'b0; start = 1'b0; msg_len = 4'd0; expected_hash = 32'h0;
    in_valid = 1'b0; in_byte = 8'h0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;

    run_check("len0", 0, 32'hFFFF_FFFF, 0, 0);
    check("len0 hash_const", hash_out, 32'hFFFF_FFFF);

    msg_bytes[0] = 8'hFF;
    run_check("len1", 1, 32'hFFFF_FE01, 0, 0);
    check("len1 hash_const", hash_out, 32'hFFFF_FE01);

    msg_bytes[0] = 8'h01; msg_bytes[1] = 8'h02;
    run_check("len2", 2, 32'h0, 0, 0);
    check("len2 hash_const", hash_out, 32'hFFFF_FF77);
    run_check("len2_gaps", 2, 32'h0, 60, 0);
    check("len2_gaps hash_const", hash_out, 32'hFFFF_FF77);

    run_check("len9_err", 9, 32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 8; i++) msg_bytes[i] = 8'h00;
    run_check("len8_zero", 8, 32'hFFFF_FFFF, 0, 1);
    check("len8 hash_const", hash_out, 32'hFFFF_FFFF);

    // Abort after three accepted bytes of an eight-byte message.
    @(negedge clk);
    start = 1'b1; msg_len = 4'd8; expected_hash = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    reset_n = 1'b1;
    run_check("post_reset_len0", 0, 32'hFFFF_FFFF, 0, 0);

    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 10);
      for (int i = 0; i < 8; i++) msg_bytes[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1 && len <= 8)
        run_check("rand_match", len, ref_hash(len), $urandom_range(0, 50), 1'($urandom_range(0, 1)));
      else
        run_check("rand", len, $urandom, $urandom_range(0, 50), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
